// File: rtl/vga_timing_gen.sv
// VGA raster timing: column/row counters with HSync, VSync, active-video flag
// and line/frame start strobes, all registered and aligned to the counters.
module vga_timing_gen #(
  parameter int unsigned TOTAL_COLS      = 800,
  parameter int unsigned TOTAL_ROWS      = 525,
  parameter int unsigned ACTIVE_COLS     = 640,
  parameter int unsigned ACTIVE_ROWS     = 480,
  parameter int unsigned H_FRONT_PORCH   = 16,
  parameter int unsigned H_SYNC_WIDTH    = 96,
  parameter int unsigned V_FRONT_PORCH   = 10,
  parameter int unsigned V_SYNC_WIDTH    = 2,
  parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Enable,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Active,
  output logic       o_Line_Start,
  output logic       o_Frame_Start
);

  localparam int unsigned CNT_W = 10;
  // One extra bit so limits equal to 1024 still compare correctly.
  localparam int unsigned CMP_W = CNT_W + 1;

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(TOTAL_COLS - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(TOTAL_ROWS - 1);

  localparam logic [CMP_W-1:0] H_ACT_LIM    = CMP_W'(ACTIVE_COLS);
  localparam logic [CMP_W-1:0] V_ACT_LIM    = CMP_W'(ACTIVE_ROWS);
  localparam logic [CMP_W-1:0] H_SYNC_FIRST = CMP_W'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [CMP_W-1:0] H_SYNC_LIM   = CMP_W'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH);
  localparam logic [CMP_W-1:0] V_SYNC_FIRST = CMP_W'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [CMP_W-1:0] V_SYNC_LIM   = CMP_W'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH);

  localparam logic SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic SYNC_OFF = ~SYNC_ON;

  // Reject timing sets that cannot be represented or do not fit in a line/frame.
  if (ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH > TOTAL_COLS) begin : g_bad_h_timing
    $fatal(1, "vga_timing_gen: horizontal active+porch+sync exceeds TOTAL_COLS");
  end
  if (ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH > TOTAL_ROWS) begin : g_bad_v_timing
    $fatal(1, "vga_timing_gen: vertical active+porch+sync exceeds TOTAL_ROWS");
  end
  if ((TOTAL_COLS > 1024) || (TOTAL_ROWS > 1024)) begin : g_bad_size
    $fatal(1, "vga_timing_gen: TOTAL_COLS/TOTAL_ROWS must not exceed 1024");
  end
  if ((TOTAL_COLS == 0) || (TOTAL_ROWS == 0)) begin : g_bad_zero
    $fatal(1, "vga_timing_gen: TOTAL_COLS/TOTAL_ROWS must be non-zero");
  end

  logic [CNT_W-1:0] col_nxt;
  logic [CNT_W-1:0] row_nxt;
  logic             line_start_nxt;
  logic             frame_start_nxt;
  logic             hsync_nxt;
  logic             vsync_nxt;
  logic             active_nxt;
  logic [CMP_W-1:0] col_ext;
  logic [CMP_W-1:0] row_ext;
  logic             col_last;
  logic             row_last;

  assign col_last = (o_Col_Count == COL_LAST);
  assign row_last = (o_Row_Count == ROW_LAST);

  // Next counter values and strobes; everything below decodes from these.
  always_comb begin
    col_nxt         = o_Col_Count;
    row_nxt         = o_Row_Count;
    line_start_nxt  = 1'b0;
    frame_start_nxt = 1'b0;
    if (i_Enable) begin
      if (col_last) begin
        col_nxt        = '0;
        line_start_nxt = 1'b1;
        if (row_last) begin
          row_nxt         = '0;
          frame_start_nxt = 1'b1;
        end else begin
          row_nxt = o_Row_Count + CNT_W'(1);
        end
      end else begin
        col_nxt = o_Col_Count + CNT_W'(1);
      end
    end
  end

  // Sync and active decode from next-state counters for zero skew.
  always_comb begin
    col_ext    = {1'b0, col_nxt};
    row_ext    = {1'b0, row_nxt};
    hsync_nxt  = SYNC_OFF;
    vsync_nxt  = SYNC_OFF;
    active_nxt = (col_ext < H_ACT_LIM) && (row_ext < V_ACT_LIM);
    if ((col_ext >= H_SYNC_FIRST) && (col_ext < H_SYNC_LIM)) begin
      hsync_nxt = SYNC_ON;
    end
    if ((row_ext >= V_SYNC_FIRST) && (row_ext < V_SYNC_LIM)) begin
      vsync_nxt = SYNC_ON;
    end
  end

  // Reset parks on the last blanking pixel so the first enabled edge is (0,0).
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Col_Count   <= COL_LAST;
      o_Row_Count   <= ROW_LAST;
      o_HSync       <= SYNC_OFF;
      o_VSync       <= SYNC_OFF;
      o_Active      <= 1'b0;
      o_Line_Start  <= 1'b0;
      o_Frame_Start <= 1'b0;
    end else begin
      o_Col_Count   <= col_nxt;
      o_Row_Count   <= row_nxt;
      o_HSync       <= hsync_nxt;
      o_VSync       <= vsync_nxt;
      o_Active      <= active_nxt;
      o_Line_Start  <= line_start_nxt;
      o_Frame_Start <= frame_start_nxt;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the VGA raster timing that the game top consumes: HSync and VSync, plus the matching column and row counters.
- Drives the i_HSync and i_VSync inputs of the frogger game top and its sync-to-count stage from the board pixel clock.
- Adds an active-video flag and line-start and frame-start strobes. Downstream logic (car controllers, score) uses these for frame-rate updates instead of free-running slow counters.

Parameters:
- TOTAL_COLS, 800, total pixel clocks per line.
- TOTAL_ROWS, 525, total lines per frame.
- ACTIVE_COLS, 640, visible pixels per line.
- ACTIVE_ROWS, 480, visible lines per frame.
- H_FRONT_PORCH, 16, pixel clocks between end of active video and start of HSync.
- H_SYNC_WIDTH, 96, HSync pulse width in pixel clocks.
- V_FRONT_PORCH, 10, lines between end of active video and start of VSync.
- V_SYNC_WIDTH, 2, VSync pulse width in lines.
- SYNC_ACTIVE_LOW, 1, sync polarity: 1 means the sync level is 0; 0 means the sync level is 1.

Ports:
- i_Clk  input  1  pixel clock (25 MHz board clock).
- i_Rst  input  1  synchronous reset, active-high.
- i_Enable  input  1  pixel-advance enable; tie high on the Go Board.
- o_HSync  output  1  horizontal sync, registered.
- o_VSync  output  1  vertical sync, registered.
- o_Col_Count  output  10  current column, 0..TOTAL_COLS-1.
- o_Row_Count  output  10  current row, 0..TOTAL_ROWS-1.
- o_Active  output  1  high when the current column is below ACTIVE_COLS and the current row is below ACTIVE_ROWS.
- o_Line_Start  output  1  one-cycle strobe on entry to column 0.
- o_Frame_Start  output  1  one-cycle strobe on entry to (column 0, row 0).

Behaviour:
- Clocking and reset:
  - One clock domain, i_Clk.
  - Reset is synchronous and active-high (i_Rst), sampled on the rising edge of i_Clk.
- Reset values (held while i_Rst=1):
  - o_Col_Count = TOTAL_COLS-1 (799).
  - o_Row_Count = TOTAL_ROWS-1 (524).
  - o_HSync and o_VSync at the inactive level: 1 when SYNC_ACTIVE_LOW=1.
  - o_Active = 0, o_Line_Start = 0, o_Frame_Start = 0.
  - Reset parks the generator on the last blanking pixel, so the first enabled cycle after reset lands on (0,0) and produces o_Frame_Start.
- Counter advance (rising edge with i_Rst=0 and i_Enable=1):
  - Column increments by 1.
  - When the column is TOTAL_COLS-1 it wraps to 0 and the row increments by 1.
  - When the row is TOTAL_ROWS-1 at a column wrap, the row wraps to 0.
  - The counters never exceed their maximum; no state outside the ranges is reachable.
- Output alignment:
  - All outputs are registered.
  - Each output is decoded from the next-state counter values, so it is coherent with o_Col_Count and o_Row_Count in the same cycle (zero-cycle skew).
- HSync:
  - At the sync level when the column is in [ACTIVE_COLS+H_FRONT_PORCH, ACTIVE_COLS+H_FRONT_PORCH+H_SYNC_WIDTH-1], i.e. 656..751 by default.
  - Inactive at all other columns.
- VSync:
  - At the sync level for the whole of rows [ACTIVE_ROWS+V_FRONT_PORCH, ACTIVE_ROWS+V_FRONT_PORCH+V_SYNC_WIDTH-1], i.e. 490..491 by default.
  - Changes state only on column-0 boundaries.
- Strobes:
  - o_Line_Start is 1 only on the cycle the column advances into 0.
  - o_Frame_Start is 1 only on the cycle the counters advance into (0,0).
  - Both are 0 on any cycle with i_Enable=0, even if the counters are parked at 0.
- i_Enable=0:
  - Counters, o_HSync, o_VSync and o_Active hold their values.
  - Both strobes are 0.
- Reset mid-frame: takes effect on the next edge and forces the reset values; no partial line is emitted afterwards.
- Elaboration checks (fatal error if violated):
  - ACTIVE_COLS+H_FRONT_PORCH+H_SYNC_WIDTH <= TOTAL_COLS.
  - ACTIVE_ROWS+V_FRONT_PORCH+V_SYNC_WIDTH <= TOTAL_ROWS.
  - TOTAL_COLS <= 1024 and TOTAL_ROWS <= 1024.
- Timing: pure counter-compare logic, no multipliers; must close at 25 MHz on iCE40.

Test Plan:
- Reset: hold i_Rst=1 for 5 cycles, then release with i_Enable=1 -> during reset col=799, row=524, HSync=VSync=1, Active=0. On the first edge after release: col=0, row=0, Active=1, Frame_Start=1, Line_Start=1. On the next cycle both strobes are 0.
- Horizontal timing: run one line -> HSync falls when col becomes 656 and rises when col becomes 752 (96 cycles low). Active is 0 from col 640 through 799. Line_Start recurs every 800 cycles.
- Vertical timing and frame period: run 2 full frames -> VSync low exactly for rows 490..491 (1600 cycles). Frame_Start pulses are exactly 420000 cycles apart. Row wraps from 524 to 0 only coincident with col 799->0.
- Enable gating: drop i_Enable for 7 cycles at col=0 row=0 -> counters and syncs frozen, Frame_Start=0 throughout the gap. On re-enable, col=1 on the next edge and no second Frame_Start occurs.
- Reset mid-frame: assert i_Rst at col=700, row=490 (HSync and VSync both active) -> next edge gives col=799, row=524, both syncs inactive. After release, Frame_Start fires on the first enabled edge.
- Polarity: SYNC_ACTIVE_LOW=0 -> HSync is high only for cols 656..751 and VSync is high only for rows 490..491. Reset level is 0.
